rbus_inject: RTL and testbench



---
 rtl/rbus_inject_pkg.sv | 31 +++
 rtl/rbus_inject_if.sv | 31 +++
 rtl/rbus_inject_fifo.sv | 60 ++++++
 rtl/rbus_inject.sv | 81 ++++++++
 tb/tb_rbus_inject.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rbus_inject_pkg.sv
// Shared ring-bus definitions: signal bundle width, bit positions,
// ID/address widths and the FIFO entry layout.
package rbus_inject_pkg;

  localparam int RBUS_WIDTH  = 16;
  localparam int RBUS_USED   = 0;
  localparam int RBUS_SECOND = 1;
  localparam int ID_W        = 10;
  localparam int ADDR_W      = 37;
  localparam int CNT_W       = 5;

  typedef logic [RBUS_WIDTH-1:0] rbus_sig_t;
  typedef logic [ID_W-1:0]       rbus_id_t;
  typedef logic [ADDR_W-1:0]     rbus_addr_t;
  typedef logic [CNT_W-1:0]      rbus_cnt_t;

  typedef struct packed {
    rbus_sig_t  signals;
    rbus_id_t   dst;
    rbus_addr_t address;
  } rbus_entry_t;

  // An injected request always occupies its ring slot.
  function automatic rbus_sig_t force_used(rbus_sig_t s);
    rbus_sig_t r;
    r            = s;
    r[RBUS_USED] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rbus_inject_if.sv
// Ring-stop input port: handshake plus the request payload presented
// by the injection stage.
interface rbus_inject_if;
  import rbus_inject_pkg::*;

  logic       rbus_rdyOut;
  logic       rbus_rdyIn;
  rbus_sig_t  rbusOut_signals;
  rbus_id_t   rbusOut_src_req;
  rbus_id_t   rbusOut_dst_req;
  rbus_addr_t rbusOut_address;

  modport master (
    output rbus_rdyOut,
    output rbusOut_signals,
    output rbusOut_src_req,
    output rbusOut_dst_req,
    output rbusOut_address,
    input  rbus_rdyIn
  );

  modport slave (
    input  rbus_rdyOut,
    input  rbusOut_signals,
    input  rbusOut_src_req,
    input  rbusOut_dst_req,
    input  rbusOut_address,
    output rbus_rdyIn
  );

endinterface

// File: rtl/rbus_inject_fifo.sv
// Register FIFO holding queued tile requests; the head entry is read
// straight from storage (no bypass path).
module rbus_inject_fifo
  import rbus_inject_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  rbus_entry_t wr_data,
  input  logic        pop,
  output rbus_entry_t head,
  output rbus_cnt_t   cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;

  rbus_entry_t mem [DEPTH];
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;

  // Storage is cleared on reset so the head never carries X into the bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // Occupancy: push and pop together leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + rbus_cnt_t'(1);
        2'b01:   cnt <= cnt - rbus_cnt_t'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rbus_inject.sv
// Tile-side injection stage in front of one ring-stop input port.
// Queues requests, presents the head when a credit is available and
// tracks outstanding requests returned by resp_done.
module rbus_inject
  import rbus_inject_pkg::*;
#(
  parameter logic [4:0] ID        = 5'd0,
  parameter int         DEPTH     = 4,
  parameter int         MAX_OUTST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  rbus_sig_t  req_signals,
  input  rbus_id_t   req_dst,
  input  rbus_addr_t req_address,
  output logic       req_stall,
  input  logic       resp_done,
  output rbus_cnt_t  fifo_cnt,
  output rbus_cnt_t  outst_cnt,
  output logic       err_underflow,
  rbus_inject_if.master ring
);

  logic        push;
  logic        pop;
  logic        credit_ok;
  rbus_entry_t wr_entry;
  rbus_entry_t head;

  assign wr_entry.signals = req_signals;
  assign wr_entry.dst     = req_dst;
  assign wr_entry.address = req_address;

  // Both handshake qualifiers come from registered counts only, so
  // rbus_rdyOut never loops back through rbus_rdyIn.
  assign req_stall   = (fifo_cnt == rbus_cnt_t'(DEPTH));
  assign credit_ok   = (outst_cnt < rbus_cnt_t'(MAX_OUTST));
  assign push        = req_valid & ~req_stall;
  assign ring.rbus_rdyOut = (fifo_cnt != '0) & credit_ok;
  assign pop         = ring.rbus_rdyOut & ring.rbus_rdyIn;

  rbus_inject_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .head    (head),
    .cnt     (fifo_cnt)
  );

  assign ring.rbusOut_signals = force_used(head.signals);
  assign ring.rbusOut_src_req = {5'b0, ID};
  assign ring.rbusOut_dst_req = head.dst;
  assign ring.rbusOut_address = head.address;

  // Credit counter: a pop consumes a credit, resp_done returns one;
  // both together cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst_cnt <= '0;
    end else if (pop && !resp_done) begin
      outst_cnt <= outst_cnt + rbus_cnt_t'(1);
    end else if (!pop && resp_done && (outst_cnt != '0)) begin
      outst_cnt <= outst_cnt - rbus_cnt_t'(1);
    end
  end

  // A completion with nothing outstanding is a tile protocol error; held until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_underflow <= 1'b0;
    end else if (resp_done && !pop && (outst_cnt == '0)) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rbus_inject.sv
// Directed and randomized bench for rbus_inject against a queue-based
// reference model of the injection stage.
module tb_rbus_inject;
  import rbus_inject_pkg::*;

  localparam logic [4:0] TID   = 5'd7;
  localparam int         DEPTH = 4;
  localparam int         MAXO  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  rbus_sig_t  req_signals = '0;
  rbus_id_t   req_dst = '0;
  rbus_addr_t req_address = '0;
  logic       req_stall;
  logic       resp_done = 1'b0;
  rbus_cnt_t  fifo_cnt;
  rbus_cnt_t  outst_cnt;
  logic       err_underflow;

  rbus_inject_if ring();

  rbus_inject #(
    .ID        (TID),
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAXO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_signals   (req_signals),
    .req_dst       (req_dst),
    .req_address   (req_address),
    .req_stall     (req_stall),
    .resp_done     (resp_done),
    .fifo_cnt      (fifo_cnt),
    .outst_cnt     (outst_cnt),
    .err_underflow (err_underflow),
    .ring          (ring)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int dropped = 0;

  rbus_entry_t mq[$];
  int          m_outst = 0;
  bit          m_err   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after a falling edge, compare the DUT with the
  // model's current state, then advance the model and wait for the next falling edge.
  task automatic step(input bit v, input rbus_sig_t s, input rbus_id_t d,
                      input rbus_addr_t a, input bit rin, input bit done);
    bit          exp_rdy;
    bit          exp_stall;
    bit          pop_e;
    bit          push_e;
    rbus_entry_t e;
    rbus_sig_t   sig_exp;
    req_valid        = v;
    req_signals      = s;
    req_dst          = d;
    req_address      = a;
    ring.rbus_rdyIn  = rin;
    resp_done        = done;
    #1;
    exp_rdy   = (mq.size() != 0) && (m_outst < MAXO);
    exp_stall = (mq.size() == DEPTH);
    chk("rdyOut",    64'(ring.rbus_rdyOut), 64'(exp_rdy));
    chk("req_stall", 64'(req_stall),        64'(exp_stall));
    chk("fifo_cnt",  64'(fifo_cnt),         64'(mq.size()));
    chk("outst_cnt", 64'(outst_cnt),        64'(m_outst));
    chk("err_uflow", 64'(err_underflow),    64'(m_err));
    if (mq.size() != 0) begin
      e       = mq[0];
      sig_exp = e.signals | (rbus_sig_t'(1) << RBUS_USED);
      chk("signals", 64'(ring.rbusOut_signals), 64'(sig_exp));
      chk("src_req", 64'(ring.rbusOut_src_req), 64'({5'b0, TID}));
      chk("dst_req", 64'(ring.rbusOut_dst_req), 64'(e.dst));
      chk("address", 64'(ring.rbusOut_address), 64'(e.address));
    end
    if (ring.rbus_rdyOut === 1'b1 && rin) pops++;
    pop_e  = exp_rdy && rin;
    push_e = v && !exp_stall;
    if (v && exp_stall) begin
      dropped++;
      $display("note: tile request while stalled is dropped (addr=%0h)", a);
    end
    if (pop_e) void'(mq.pop_front());
    if (push_e) begin
      e.signals = s;
      e.dst     = d;
      e.address = a;
      mq.push_back(e);
    end
    if (pop_e && !done) m_outst++;
    else if (done && !pop_e) begin
      if (m_outst == 0) m_err = 1'b1;
      else m_outst--;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rin, input bit done);
    step(1'b0, '0, '0, '0, rin, done);
  endtask

  task automatic push_rand(input bit rin);
    step(1'b1, rbus_sig_t'($urandom), rbus_id_t'($urandom),
         rbus_addr_t'({$urandom, $urandom}), rin, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ring.rbus_rdyIn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    chk("rst_outst",    64'(outst_cnt), 64'd0);
    chk("rst_rdyOut",   64'(ring.rbus_rdyOut), 64'd0);
    chk("rst_stall",    64'(req_stall), 64'd0);
    chk("rst_err",      64'(err_underflow), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // single request, minimum latency one cycle
    step(1'b1, 16'h0a50, 10'd5, 37'h1_0000_0040, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("single_outst", 64'(outst_cnt), 64'd1);

    // fill while ring stop is busy, then drain in order
    for (int i = 0; i < 4; i++)
      step(1'b1, rbus_sig_t'($urandom), rbus_id_t'(i + 1), rbus_addr_t'(37'h20 + i), 1'b0, 1'b0);
    step(1'b1, 16'hffff, 10'h3ff, 37'h1f_ffff_ffff, 1'b0, 1'b0);
    chk("full_dropped", 64'(dropped), 64'd1);
    pops = 0;
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    chk("drain_pops", 64'(pops), 64'd4);
    for (int i = 0; i < 5; i++) idle(1'b0, 1'b1);

    // credit limit
    pops = 0;
    for (int i = 0; i < 10; i++) push_rand(1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
    chk("limit_pops", 64'(pops), 64'd8);
    #1;
    chk("limit_fifo", 64'(fifo_cnt), 64'd2);
    chk("limit_rdy",  64'(ring.rbus_rdyOut), 64'd0);
    pops = 0;
    idle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
    chk("reopen_pops", 64'(pops), 64'd1);

    // simultaneous pop and resp_done at outst_cnt == 3
    for (int i = 0; i < 5; i++) idle(1'b0, 1'b1);
    #1;
    chk("pre_sim_outst", 64'(outst_cnt), 64'd3);
    idle(1'b1, 1'b1);
    #1;
    chk("pop_done_outst", 64'(outst_cnt), 64'd3);

    // simultaneous push and pop at fifo_cnt == 2
    push_rand(1'b0);
    push_rand(1'b0);
    push_rand(1'b1);
    #1;
    chk("push_pop_fifo", 64'(fifo_cnt), 64'd2);

    // underflow
    for (int i = 0; i < 40 && m_outst > 0; i++) idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    #1;
    chk("uflow_set", 64'(err_underflow), 64'd1);
    idle(1'b0, 1'b0);
    #1;
    chk("uflow_hold", 64'(err_underflow), 64'd1);
    chk("uflow_outst", 64'(outst_cnt), 64'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && mq.size() < DEPTH)
        step(1'b1, rbus_sig_t'($urandom), rbus_id_t'($urandom),
             rbus_addr_t'({$urandom, $urandom}), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) == 0));
      else
        idle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
    end

    // build fifo_cnt = 3, outst_cnt = 5, then reset between edges
    for (int i = 0; i < 64 && mq.size() != 0; i++) idle(1'b1, m_outst >= MAXO);
    for (int i = 0; i < 40 && m_outst > 0; i++) idle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) push_rand(1'b1);
    idle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push_rand(1'b0);
    #1;
    chk("pre_rst_fifo",  64'(fifo_cnt), 64'd3);
    chk("pre_rst_outst", 64'(outst_cnt), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_fifo",  64'(fifo_cnt), 64'd0);
    chk("mid_rst_outst", 64'(outst_cnt), 64'd0);
    chk("mid_rst_rdy",   64'(ring.rbus_rdyOut), 64'd0);
    chk("mid_rst_err",   64'(err_underflow), 64'd0);
    mq.delete();
    m_outst = 0;
    m_err   = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    step(1'b1, 16'h1234, 10'h2a3, 37'h0_dead_beef, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    #1;
    chk("post_rst_fifo",  64'(fifo_cnt), 64'd0);
    chk("post_rst_outst", 64'(outst_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
